onewire_scratchpad_rx: RTL and testbench
========================================

Name: onewire_scratchpad_rx

Overview:
- Downstream consumer of the 1-Wire master's read path.
- Accepts bytes from the master over a valid/ready handshake and assembles a NUM_BYTES frame, LSB-first as received on the bus.
- Checks the frame with the Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, bit-serial) and publishes the decoded sensor fields together with a crc_ok flag.
- Runs in the 27 MHz clk domain alongside the master.

Parameters:
- NUM_BYTES, 9, frame length in bytes including the trailing CRC byte. Legal range 5..16.

Ports:
- clk  input  1  system clock, 27 MHz
- rst_n  input  1  asynchronous active-low reset
- byte_valid  input  1  upstream byte available
- byte_data  input  8  received byte, bit0 = first bit read from the bus
- byte_ready  output  1  block can accept a byte this cycle
- abort  input  1  synchronous frame discard (e.g. no presence pulse)
- frame_valid  output  1  one-cycle pulse: a frame completed and the outputs were updated
- crc_ok  output  1  1 = CRC residue of the completed frame is 0x00
- temp_raw  output  16  {byte1, byte0}
- alarm_hi  output  8  byte2
- alarm_lo  output  8  byte3
- config  output  8  byte4

Behaviour:
- Reset (async, rst_n=0): state=COLLECT, byte_cnt=0, bit_cnt=0, crc=0x00, frame_valid=0, crc_ok=0, temp_raw=0x0000, alarm_hi=0x00, alarm_lo=0x00, config=0x00. byte_ready follows state, so it is 1 after reset.
- States: COLLECT, SHIFT.
- byte_ready = (state==COLLECT). It is combinational from the state register only and does not depend on byte_valid.
- Accept = byte_valid && byte_ready, sampled at the clk edge.
  - On accept: latch byte_data into the shift register.
  - If byte_cnt<=4, also latch it into working field register byte_cnt.
  - bit_cnt=0, state goes to SHIFT.
- SHIFT, one bit per cycle, LSB first:
  - fb = crc[0] ^ sr[0]
  - crc = (crc>>1) ^ (fb ? 0x8C : 0x00)
  - sr = sr>>1, bit_cnt++
- On the edge processing bit_cnt==7:
  - If byte_cnt==NUM_BYTES-1:
    - Copy the working fields to the outputs.
    - crc_ok = (next crc==0x00).
    - frame_valid=1 for exactly one cycle.
    - Clear crc and byte_cnt.
    - state goes to COLLECT.
  - Otherwise: byte_cnt++ and state goes to COLLECT.
- Timing:
  - A byte accepted at edge T gets its last bit processed at edge T+8.
  - byte_ready is 1 again in the cycle after edge T+8.
  - frame_valid is high in the cycle after edge T+8 of the final byte.
  - Maximum throughput is one byte per 9 cycles.
- Upstream must hold byte_valid/byte_data while byte_ready=0. Nothing is dropped and nothing is double-counted.
- The CRC byte itself is fed through the CRC, so a correct frame leaves residue 0x00.
- Outputs hold their values between frames. A frame with a bad CRC still updates the fields, with crc_ok=0.
- abort=1 (synchronous, highest priority):
  - state=COLLECT, byte_cnt=0, crc=0.
  - No frame_valid pulse; output registers are unchanged.
  - Abort wins over a simultaneous accept, and over a simultaneous final-bit edge.
- rst_n asserted mid-frame clears everything immediately, regardless of clk.
- byte_cnt is 4 bits wide and never exceeds NUM_BYTES-1, so it does not wrap.

Test Plan:
- Send 50 05 4B 46 7F FF 0C 10 1C, byte_valid held high throughout → byte_ready low 8 cycles after each accept. A single frame_valid pulse occurs 9 cycles after the last accept, with temp_raw=0x0550, alarm_hi=0x4B, alarm_lo=0x46, config=0x7F, crc_ok=1.
- Same frame with byte1=0x06 → frame_valid pulse, crc_ok=0, temp_raw=0x0650.
- Nine bytes of 0x00 → crc_ok=1 and temp_raw=0x0000. Then a second valid frame back-to-back → two frame_valid pulses, 81 cycles apart at full rate.
- Accept 4 bytes, assert abort for 1 cycle (also coinciding with a byte_valid), then send the full valid frame → exactly one frame_valid pulse, fields as in scenario 1, and the byte offered during abort is not counted.
- Pulse rst_n low mid-SHIFT of byte 3, asynchronously between edges → all outputs read 0 immediately and byte_ready=1 after release. The next full frame decodes correctly.
- Upstream stalls randomly, with byte_valid dropping for 0..20 cycles between bytes → results identical to scenario 1, and no accept occurs while byte_ready=0.

Source files
------------

// File: rtl/onewire_scratchpad_rx.sv
// 1-Wire scratchpad receiver: collects NUM_BYTES bytes LSB-first, runs the Dallas CRC-8 bit-serially
// and publishes the sensor fields with a crc_ok flag. One byte per 9 cycles; byte_ready low while shifting.
module onewire_scratchpad_rx #(
  parameter int NUM_BYTES = 9
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic        abort_i,
  output logic        frame_valid_o,
  output logic        crc_ok_o,
  output logic [15:0] temp_raw_o,
  output logic [7:0]  alarm_hi_o,
  output logic [7:0]  alarm_lo_o,
  output logic [7:0]  config_o
);

  localparam logic [3:0] LAST = 4'(NUM_BYTES - 1);

  typedef enum logic {COLLECT, SHIFT} state_t;

  state_t          state_q;
  logic [3:0]      byte_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      crc_q;
  logic [7:0]      sr_q;
  logic [4:0][7:0] field_q;
  logic            frame_valid_q;
  logic            crc_ok_q;
  logic [15:0]     temp_q;
  logic [7:0]      alarm_hi_q;
  logic [7:0]      alarm_lo_q;
  logic [7:0]      config_q;

  logic            accept;
  logic            fb;
  logic [7:0]      crc_d;

  assign byte_ready_o = (state_q == COLLECT);
  assign accept       = byte_valid_i && byte_ready_o;

  // Reflected form of x^8+x^5+x^4+1: the bus bit enters at crc[0].
  assign fb    = crc_q[0] ^ sr_q[0];
  assign crc_d = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= COLLECT;
      byte_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      crc_q         <= '0;
      sr_q          <= '0;
      field_q       <= '0;
      frame_valid_q <= 1'b0;
      crc_ok_q      <= 1'b0;
      temp_q        <= '0;
      alarm_hi_q    <= '0;
      alarm_lo_q    <= '0;
      config_q      <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      if (abort_i) begin
        state_q    <= COLLECT;
        byte_cnt_q <= '0;
        crc_q      <= '0;
      end else begin
        case (state_q)
          COLLECT: begin
            if (accept) begin
              sr_q      <= byte_data_i;
              bit_cnt_q <= '0;
              state_q   <= SHIFT;
              for (int i = 0; i < 5; i++) begin
                if (byte_cnt_q == 4'(i)) field_q[i] <= byte_data_i;
              end
            end
          end
          SHIFT: begin
            crc_q     <= crc_d;
            sr_q      <= {1'b0, sr_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= COLLECT;
              if (byte_cnt_q == LAST) begin
                // Residue includes the CRC byte itself, so a clean frame ends at zero.
                temp_q        <= {field_q[1], field_q[0]};
                alarm_hi_q    <= field_q[2];
                alarm_lo_q    <= field_q[3];
                config_q      <= field_q[4];
                crc_ok_q      <= (crc_d == 8'h00);
                frame_valid_q <= 1'b1;
                crc_q         <= '0;
                byte_cnt_q    <= '0;
              end else begin
                byte_cnt_q <= byte_cnt_q + 4'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign frame_valid_o = frame_valid_q;
  assign crc_ok_o      = crc_ok_q;
  assign temp_raw_o    = temp_q;
  assign alarm_hi_o    = alarm_hi_q;
  assign alarm_lo_o    = alarm_lo_q;
  assign config_o      = config_q;

endmodule

// File: tb/tb_onewire_scratchpad_rx.sv
// Directed bench for onewire_scratchpad_rx: known DS18B20 scratchpad frames, abort, async reset, stalls.
module tb_onewire_scratchpad_rx;

  logic        clk;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        abort;
  logic        frame_valid;
  logic        crc_ok;
  logic [15:0] temp_raw;
  logic [7:0]  alarm_hi;
  logic [7:0]  alarm_lo;
  logic [7:0]  cfg;

  // Byte 0 sits in the low bits.
  localparam logic [71:0] GOOD = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};
  localparam logic [71:0] BAD  = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h06, 8'h50};
  localparam logic [71:0] ZERO = 72'h0;

  int n_checks = 0;
  int n_err    = 0;

  int cyc = 0;
  int acc_cnt, fv_cnt, busy_cnt, min_gap, last_acc;
  int          snap_cyc [4];
  logic [15:0] snap_temp[4];
  logic        snap_crc [4];

  onewire_scratchpad_rx #(.NUM_BYTES(9)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .abort_i      (abort),
    .frame_valid_o(frame_valid),
    .crc_ok_o     (crc_ok),
    .temp_raw_o   (temp_raw),
    .alarm_hi_o   (alarm_hi),
    .alarm_lo_o   (alarm_lo),
    .config_o     (cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle observer: inputs are driven just after posedge, so values here apply at the next edge.
  always @(negedge clk) begin
    cyc++;
    if (!byte_ready) busy_cnt++;
    if (byte_valid && byte_ready && !abort && rst_n) begin
      if (acc_cnt > 0 && (cyc - last_acc) < min_gap) min_gap = cyc - last_acc;
      acc_cnt++;
      last_acc = cyc;
    end
    if (frame_valid) begin
      if (fv_cnt < 4) begin
        snap_cyc[fv_cnt]  = cyc;
        snap_temp[fv_cnt] = temp_raw;
        snap_crc[fv_cnt]  = crc_ok;
      end
      fv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    acc_cnt  = 0;
    fv_cnt   = 0;
    busy_cnt = 0;
    min_gap  = 1000;
    last_acc = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int n;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_valid = 1'b1;
    byte_data  = d;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("accept_timeout", 32'(n), 32'd0);
    tick();
  endtask

  task automatic send_frame(input logic [71:0] f, input int maxgap);
    for (int i = 0; i < 9; i++) begin
      send_byte(f[8*i +: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_good(input string p);
    check({p, "_acc"},   32'(acc_cnt), 32'd9);
    check({p, "_fvcnt"}, 32'(fv_cnt),  32'd1);
    check({p, "_temp"},  32'(temp_raw), 32'h0550);
    check({p, "_ahi"},   32'(alarm_hi), 32'h4B);
    check({p, "_alo"},   32'(alarm_lo), 32'h46);
    check({p, "_cfg"},   32'(cfg),      32'h7F);
    check({p, "_crc"},   32'(crc_ok),   32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    abort      = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_fv",    32'(frame_valid), 32'd0);
    check("rst_crc",   32'(crc_ok),     32'd0);
    check("rst_temp",  32'(temp_raw),   32'd0);
    check("rst_cfg",   32'(cfg),        32'd0);
    rst_n = 1'b1;
    tick();

    // Good frame at full rate.
    clr();
    send_frame(GOOD, 0);
    repeat (12) tick();
    check_good("s1");
    check("s1_gap",     32'(min_gap),                32'd9);
    check("s1_busy",    32'(busy_cnt),               32'd72);
    check("s1_latency", 32'(snap_cyc[0] - last_acc), 32'd9);

    // Corrupted byte1: fields still update, crc_ok drops.
    clr();
    send_frame(BAD, 0);
    repeat (12) tick();
    check("s2_fvcnt", 32'(fv_cnt),   32'd1);
    check("s2_temp",  32'(temp_raw), 32'h0650);
    check("s2_ahi",   32'(alarm_hi), 32'h4B);
    check("s2_crc",   32'(crc_ok),   32'd0);

    // All-zero frame then good frame back-to-back.
    clr();
    send_frame(ZERO, 0);
    send_frame(GOOD, 0);
    repeat (12) tick();
    check("s3_fvcnt", 32'(fv_cnt),                     32'd2);
    check("s3_temp0", 32'(snap_temp[0]),               32'h0000);
    check("s3_crc0",  32'(snap_crc[0]),                32'd1);
    check("s3_temp1", 32'(snap_temp[1]),               32'h0550);
    check("s3_crc1",  32'(snap_crc[1]),                32'd1);
    check("s3_space", 32'(snap_cyc[1] - snap_cyc[0]),  32'd81);

    // Four bytes, abort coinciding with an offered byte, then a full frame.
    clr();
    for (int i = 0; i < 4; i++) send_byte(GOOD[8*i +: 8], 0);
    byte_valid = 1'b0;
    repeat (8) tick();
    check("s4_ready_pre", 32'(byte_ready), 32'd1);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    check("s4_ready_post", 32'(byte_ready), 32'd1);
    check("s4_hold_temp",  32'(temp_raw),   32'h0550);
    check("s4_acc_pre",    32'(acc_cnt),    32'd4);
    check("s4_fv_pre",     32'(fv_cnt),     32'd0);
    clr();
    send_frame(GOOD, 0);
    repeat (12) tick();
    check_good("s4");

    // Async reset in the middle of byte 3's shift.
    for (int i = 0; i < 4; i++) send_byte(BAD[8*i +: 8], 0);
    byte_valid = 1'b0;
    repeat (3) tick();
    check("s5_busy", 32'(byte_ready), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("s5_ready", 32'(byte_ready), 32'd1);
    check("s5_temp",  32'(temp_raw),   32'd0);
    check("s5_ahi",   32'(alarm_hi),   32'd0);
    check("s5_alo",   32'(alarm_lo),   32'd0);
    check("s5_cfg",   32'(cfg),        32'd0);
    check("s5_crc",   32'(crc_ok),     32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("s5_ready_rel", 32'(byte_ready), 32'd1);
    clr();
    send_frame(GOOD, 0);
    repeat (12) tick();
    check_good("s5");

    // Random upstream stalls.
    clr();
    send_frame(GOOD, 20);
    repeat (12) tick();
    check_good("s6");
    check("s6_gapmin", 32'(min_gap >= 9), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
